// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
// Expected tables are indexed by input vector: bit[v] = F(v).
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  localparam logic [1:0] EXP_NOT  = 2'b01;
  localparam logic [3:0] EXP_AND2 = 4'b1000;
  localparam logic [3:0] EXP_OR2  = 4'b1110;
  localparam logic [3:0] EXP_XOR2 = 4'b0110;

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Signal bundle between the sequencer and the gate under test / its controller.
// master = sequencer side, slave = stimulus/gate side.
interface gate_test_sequencer_if #(
  parameter int N_IN  = 1,
  parameter int CNT_W = 4
);
  logic             start;
  logic [N_IN-1:0]  stim;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] fail_cnt;
  logic [N_IN-1:0]  first_fail_vec;

  modport master (
    input  start, dut_out,
    output stim, busy, done, pass, fail_cnt, first_fail_vec
  );

  modport slave (
    output start, dut_out,
    input  stim, busy, done, pass, fail_cnt, first_fail_vec
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Sweeps all input vectors of a small gate, holds each for a settle window,
// then checks the gate output against EXP_TABLE and reports the result.
//
// state  | meaning
// IDLE   | waiting for start; last result held on outputs
// SETTLE | current vector driven, settle timer counting down
// CHECK  | compare gate output, advance vector or finish
// DONE   | one-cycle done pulse, publish pass
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int                   N_IN       = 1,
  parameter int                   SETTLE_CYC = 2,
  parameter logic [(2**N_IN)-1:0] EXP_TABLE  = EXP_NOT,
  parameter int                   CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_test_sequencer_if.master io_seq
);

  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]   LAST_VEC  = '1;

  seq_state_e       r_state, w_state_nxt;
  logic [SCNT_W-1:0] r_scnt, w_scnt_nxt;
  logic [N_IN-1:0]  r_stim, w_stim_nxt;
  logic [N_IN-1:0]  r_ffv, w_ffv_nxt;
  logic [CNT_W-1:0] r_fail_cnt, w_fail_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             w_mismatch;

  // Case-equality so an unknown gate output is scored as a failure.
  assign w_mismatch = (io_seq.dut_out !== EXP_TABLE[r_stim]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_scnt_nxt     = r_scnt;
    w_stim_nxt     = r_stim;
    w_ffv_nxt      = r_ffv;
    w_fail_cnt_nxt = r_fail_cnt;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_pass_nxt     = r_pass;
    case (r_state)
      ST_IDLE: begin
        if (io_seq.start) begin
          w_state_nxt    = ST_SETTLE;
          w_stim_nxt     = '0;
          w_fail_cnt_nxt = '0;
          w_pass_nxt     = 1'b0;
          w_ffv_nxt      = '0;
          w_busy_nxt     = 1'b1;
          w_scnt_nxt     = SCNT_LOAD;
        end
      end
      ST_SETTLE: begin
        if (r_scnt == '0) w_state_nxt = ST_CHECK;
        else              w_scnt_nxt  = r_scnt - SCNT_W'(1);
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          if (r_fail_cnt != '1) w_fail_cnt_nxt = r_fail_cnt + CNT_W'(1);
          if (r_fail_cnt == '0) w_ffv_nxt = r_stim;
        end
        if (r_stim == LAST_VEC) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_stim_nxt  = r_stim + N_IN'(1);
          w_scnt_nxt  = SCNT_LOAD;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_DONE: begin
        w_busy_nxt  = 1'b0;
        w_pass_nxt  = (r_fail_cnt == '0);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt     <= '0;
      r_stim     <= '0;
      r_ffv      <= '0;
      r_fail_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_scnt     <= w_scnt_nxt;
      r_stim     <= w_stim_nxt;
      r_ffv      <= w_ffv_nxt;
      r_fail_cnt <= w_fail_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
    end
  end

  assign io_seq.stim           = r_stim;
  assign io_seq.busy           = r_busy;
  assign io_seq.done           = r_done;
  assign io_seq.pass           = r_pass;
  assign io_seq.fail_cnt       = r_fail_cnt;
  assign io_seq.first_fail_vec = r_ffv;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: a 1-input sequencer (NOT table) and a 2-input one (AND table)
// driven against behavioural gate models with hand-computed expectations.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_test_sequencer_if #(.N_IN(1), .CNT_W(4)) i1 ();
  gate_test_sequencer_if #(.N_IN(2), .CNT_W(4)) i2 ();

  gate_test_sequencer #(.N_IN(1), .SETTLE_CYC(2), .EXP_TABLE(EXP_NOT), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .io_seq(i1)
  );
  gate_test_sequencer #(.N_IN(2), .SETTLE_CYC(2), .EXP_TABLE(EXP_AND2), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .io_seq(i2)
  );

  // gate models: mode1 0=NOT 1=tied0 2=tied1; mode2 0=AND 1=OR 2=XOR
  int mode1 = 0;
  int mode2 = 0;
  assign i1.dut_out = (mode1 == 0) ? ~i1.stim[0] : (mode1 == 1) ? 1'b0 : 1'b1;
  assign i2.dut_out = (mode2 == 0) ? &i2.stim : (mode2 == 1) ? |i2.stim : ^i2.stim;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int done_cyc, done_n;
  int s_at [0:31];
  int b_at [0:31];

  // start pulse, then observe a fixed window; optionally re-pulse start in cycle 'repulse'
  task automatic sweep1(input int repulse);
    done_cyc = -1;
    done_n   = 0;
    i1.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      i1.start = (c == repulse);
      s_at[c] = int'(i1.stim);
      b_at[c] = int'(i1.busy);
      if (i1.done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic sweep2();
    done_cyc = -1;
    done_n   = 0;
    i2.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      i2.start = 1'b0;
      s_at[c] = int'(i2.stim);
      b_at[c] = int'(i2.busy);
      if (i2.done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  int d1, d2, pass_hi, viol, pass8, pass1;

  initial begin
    i1.start = 1'b0;
    i2.start = 1'b0;
    tick();
    tick();
    check("rst_stim", i1.stim, 0);
    check("rst_busy", i1.busy, 0);
    check("rst_done", i1.done, 0);
    check("rst_pass", i1.pass, 0);
    check("rst_fail", i1.fail_cnt, 0);
    check("rst_ffv", i1.first_fail_vec, 0);
    check("rst_busy2", i2.busy, 0);
    rst = 1'b0;
    tick();

    // 1: NOT gate, correct
    mode1 = 0;
    sweep1(0);
    check("t1_done_cyc", done_cyc, 7);
    check("t1_done_n", done_n, 1);
    check("t1_stim_c1", s_at[1], 0);
    check("t1_stim_c4", s_at[4], 1);
    check("t1_busy_c1", b_at[1], 1);
    check("t1_busy_c7", b_at[7], 1);
    check("t1_busy_c8", b_at[8], 0);
    check("t1_pass", i1.pass, 1);
    check("t1_fail", i1.fail_cnt, 0);

    // 2: output tied low -> vector 0 fails
    mode1 = 1;
    sweep1(0);
    check("t2_done_cyc", done_cyc, 7);
    check("t2_fail", i1.fail_cnt, 1);
    check("t2_ffv", i1.first_fail_vec, 0);
    check("t2_pass", i1.pass, 0);

    // 2b: output tied high -> vector 1 fails
    mode1 = 2;
    sweep1(0);
    check("t2b_fail", i1.fail_cnt, 1);
    check("t2b_ffv", i1.first_fail_vec, 1);
    check("t2b_pass", i1.pass, 0);

    // 3: two-input AND table
    mode2 = 0;
    sweep2();
    check("t3_done_cyc", done_cyc, 13);
    check("t3_done_n", done_n, 1);
    check("t3_stim_c1", s_at[1], 0);
    check("t3_stim_c4", s_at[4], 1);
    check("t3_stim_c7", s_at[7], 2);
    check("t3_stim_c10", s_at[10], 3);
    check("t3_stim_c12", s_at[12], 3);
    check("t3_stim_nowrap", s_at[15], 3);
    check("t3_pass", i2.pass, 1);
    check("t3_fail", i2.fail_cnt, 0);

    mode2 = 1;
    sweep2();
    check("t3_or_fail", i2.fail_cnt, 2);
    check("t3_or_ffv", i2.first_fail_vec, 1);
    check("t3_or_pass", i2.pass, 0);

    mode2 = 2;
    sweep2();
    check("t3_xor_fail", i2.fail_cnt, 3);
    check("t3_xor_ffv", i2.first_fail_vec, 1);

    // 4: start re-pulsed during SETTLE of vector 0
    mode1 = 0;
    sweep1(1);
    check("t4_done_cyc", done_cyc, 7);
    check("t4_done_n", done_n, 1);
    check("t4_pass", i1.pass, 1);

    // 5: reset during CHECK of vector 1
    mode1 = 1;
    i1.start = 1'b1;
    tick();
    i1.start = 1'b0;
    for (int c = 2; c <= 6; c++) tick();
    check("t5_pre_stim", i1.stim, 1);
    check("t5_pre_fail", i1.fail_cnt, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_stim", i1.stim, 0);
    check("t5_rst_busy", i1.busy, 0);
    check("t5_rst_done", i1.done, 0);
    check("t5_rst_pass", i1.pass, 0);
    check("t5_rst_fail", i1.fail_cnt, 0);
    check("t5_rst_ffv", i1.first_fail_vec, 0);
    tick();
    rst = 1'b0;
    tick();
    mode1 = 0;
    sweep1(0);
    check("t5_done_cyc", done_cyc, 7);
    check("t5_pass", i1.pass, 1);
    check("t5_fail", i1.fail_cnt, 0);

    // 6: start held high for 20 cycles
    d1 = -1; d2 = -1; done_n = 0; pass_hi = 0; viol = 0; pass8 = -1; pass1 = -1;
    i1.start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      i1.start = (c < 20);
      if (i1.done) begin
        done_n++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (i1.pass) pass_hi++;
      if (i1.pass && i1.busy) viol++;
      if (c == 1) pass1 = int'(i1.pass);
      if (c == 8) pass8 = int'(i1.pass);
    end
    check("t6_done1", d1, 7);
    check("t6_done_gap", d2 - d1, 8);
    check("t6_done_n", done_n, 3);
    check("t6_pass_c1", pass1, 0);
    check("t6_pass_c8", pass8, 1);
    check("t6_pass_busy", viol, 0);
    check("t6_pass_hi", pass_hi, 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
